// File: rtl/sar5_scan_ctrl.sv
// Scan sequencer for the 5-bit SAR ADC core: walks the enabled channels, settles the mux,
// runs one serial conversion per channel and hands results out on a valid/ready port.
// Build option: SAR_AVG4_EN averages four back-to-back conversions per channel.
module sar5_scan_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int CH_W          = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              busy,
    output logic [CH_W-1:0]   mux_sel,
    output logic              sar_resetn,
    input  logic              sar_serial,
    output logic [4:0]        res_data,
    output logic [CH_W-1:0]   res_ch,
    output logic              res_valid,
    input  logic              res_ready
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SEL, SETTLE, CONV, OUT} state_t;

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] mask_q;
    logic              first_q;
    logic [SW-1:0]     settle_cnt;
    logic [2:0]        bit_cnt;
    logic [3:0]        shift_q;

    logic              nxt_found, low_found;
    logic [CH_W-1:0]   nxt_ch, low_ch;
    logic              settle_done, conv_last, conv_done;
    logic [4:0]        sample;

`ifdef SAR_AVG4_EN
    logic [1:0]        conv_idx;
    logic [6:0]        acc;
    logic [6:0]        sum;
`endif

    // Descending loop so the lowest qualifying index is the one that sticks.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        low_found = 1'b0;
        low_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (first_q || (CH_W'(i) > mux_sel))) begin
                nxt_found = 1'b1;
                nxt_ch    = CH_W'(i);
            end
            if (ch_mask[i]) begin
                low_found = 1'b1;
                low_ch    = CH_W'(i);
            end
        end
    end

    assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign conv_last   = (bit_cnt == 3'd5);
    assign sample      = {shift_q, sar_serial};

`ifdef SAR_AVG4_EN
    assign sum       = acc + 7'(sample);
    assign conv_done = conv_last && (conv_idx == 2'd3);
`else
    assign conv_done = conv_last;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (start && (|ch_mask)) state_nxt = SEL;
            SEL: begin
                if (nxt_found)                     state_nxt = SETTLE;
                else if (continuous && low_found)  state_nxt = SETTLE;
                else                               state_nxt = IDLE;
            end
            SETTLE: if (settle_done) state_nxt = CONV;
            CONV:   if (conv_done)   state_nxt = OUT;
            OUT:    if (res_ready)   state_nxt = SEL;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mask_q     <= '0;
            first_q    <= 1'b0;
            mux_sel    <= '0;
            settle_cnt <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            sar_resetn <= 1'b0;
            res_data   <= '0;
            res_ch     <= '0;
            res_valid  <= 1'b0;
`ifdef SAR_AVG4_EN
            conv_idx   <= '0;
            acc        <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && (|ch_mask)) begin
                        mask_q  <= ch_mask;
                        first_q <= 1'b1;
                    end
                end
                SEL: begin
                    settle_cnt <= '0;
                    first_q    <= 1'b0;
                    if (nxt_found) begin
                        mux_sel <= nxt_ch;
                    end else if (continuous) begin
                        // Pass finished: restart from the freshly sampled mask.
                        mask_q <= ch_mask;
                        if (low_found) mux_sel <= low_ch;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + SW'(1);
                    if (settle_done) begin
                        sar_resetn <= 1'b1;
                        bit_cnt    <= '0;
`ifdef SAR_AVG4_EN
                        conv_idx   <= '0;
`endif
                    end
                end
                CONV: begin
                    bit_cnt <= conv_last ? 3'd0 : bit_cnt + 3'd1;
                    // Cycle 1 is the core's first decision; bits arrive in cycles 2..6.
                    if (bit_cnt != 3'd0 && !conv_last) shift_q <= {shift_q[2:0], sar_serial};
`ifdef SAR_AVG4_EN
                    // The core stays released across the four conversions.
                    if (conv_last) begin
                        if (conv_idx == 2'd3) begin
                            acc      <= '0;
                            res_data <= sum[6:2];
                        end else begin
                            acc      <= sum;
                        end
                        conv_idx <= conv_idx + 2'd1;
                    end
`else
                    if (conv_last) res_data <= sample;
`endif
                    if (conv_done) begin
                        sar_resetn <= 1'b0;
                        res_ch     <= mux_sel;
                        res_valid  <= 1'b1;
                    end
                end
                OUT: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sar5_scan_ctrl.sv
// Scoreboarded bench for sar5_scan_ctrl: a behavioural SAR core feeds per-channel codes,
// expected results are queued per pass and a monitor checks every accepted result.
module tb_sar5_scan_ctrl;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int SETTLE = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic              busy;
    logic [CH_W-1:0]   mux_sel;
    logic              sar_resetn;
    logic              sar_serial = 1'b0;
    logic [4:0]        res_data;
    logic [CH_W-1:0]   res_ch;
    logic              res_valid;
    logic              res_ready = 1'b1;

    sar5_scan_ctrl #(.NUM_CH(NUM_CH), .CH_W(CH_W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .resetn(resetn), .start(start), .continuous(continuous), .ch_mask(ch_mask),
        .busy(busy), .mux_sel(mux_sel), .sar_resetn(sar_resetn), .sar_serial(sar_serial),
        .res_data(res_data), .res_ch(res_ch), .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [4:0]      data;
    } exp_t;

    exp_t       q[$];
    logic [4:0] core_val [0:NUM_CH-1];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_acc = 0;
    int         hi_cnt = 0;
    logic       rnd_ready = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural SAR core: while released, presents the channel's code MSB first from cycle 2.
    always @(posedge clk) begin
        #1;
        if (sar_resetn) begin
            hi_cnt++;
            if (hi_cnt >= 2 && hi_cnt <= 6) sar_serial = core_val[mux_sel][6 - hi_cnt];
            else                            sar_serial = 1'($urandom_range(0, 1));
        end else begin
            if (hi_cnt != 0 && resetn) chk("sar_release_cycles", hi_cnt, 6);
            hi_cnt     = 0;
            sar_serial = 1'($urandom_range(0, 1));
        end
    end

    always @(posedge clk) begin
        #2;
        if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
    end

    logic            stall_prev = 1'b0;
    logic [4:0]      hold_d;
    logic [CH_W-1:0] hold_c;

    always @(negedge clk) begin
        if (resetn && res_valid) begin
            if (stall_prev) begin
                chk("hold_data", int'(res_data), int'(hold_d));
                chk("hold_ch", int'(res_ch), int'(hold_c));
            end
            if (res_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("res_ch", int'(res_ch), int'(e.ch));
                    chk("res_data", int'(res_data), int'(e.data));
                end
                n_acc++;
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                hold_d     = res_data;
                hold_c     = res_ch;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Reference: one result per enabled channel, ascending index, value = that channel's code.
    task automatic push_pass(input logic [NUM_CH-1:0] m);
        for (int i = 0; i < NUM_CH; i++)
            if (m[i]) q.push_back('{ch: CH_W'(i), data: core_val[i]});
    endtask

    task automatic do_start(input logic [NUM_CH-1:0] m);
        @(posedge clk); #1;
        ch_mask = m;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_idle"}, int'(busy), 0);
        chk({name, "_drained"}, q.size(), 0);
    endtask

    task automatic rand_vals();
        for (int i = 0; i < NUM_CH; i++) core_val[i] = 5'($urandom_range(0, 31));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bad, n, base;
        logic [4:0] d;
        logic [CH_W-1:0] c;
        logic [NUM_CH-1:0] m;

        rand_vals();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_mux_sel", int'(mux_sel), 0);
        chk("rst_sar_resetn", int'(sar_resetn), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_res_ch", int'(res_ch), 0);
        resetn = 1'b1;

        // Directed two-channel pass
        core_val[1] = 5'b10110;
        core_val[3] = 5'b01001;
        push_pass(4'b1010);
        do_start(4'b1010);
        chk("busy_after_start", int'(busy), 1);
        wait_idle("pass_1010", 200);

        // Latency from SEL to res_valid; mux stable from SETTLE onward
        rand_vals();
        push_pass(4'b0001);
        @(posedge clk); #1;
        ch_mask = 4'b0001;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        bad = 0;
        while (!res_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (mux_sel !== 2'd0) bad++;
        end
        chk("latency", lat, 1 + SETTLE + 6);
        chk("mux_stable", bad, 0);
        wait_idle("single_ch", 100);

        // Backpressure stall
        rand_vals();
        res_ready = 1'b0;
        push_pass(4'b1111);
        do_start(4'b1111);
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_valid_seen", int'(res_valid), 1);
        d   = res_data;
        c   = res_ch;
        bad = 0;
        chk("stall_first_ch", int'(c), 0);
        repeat (20) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || sar_resetn !== 1'b0 || res_data !== d || res_ch !== c) bad++;
        end
        chk("stall_hold", bad, 0);
        res_ready = 1'b1;
        wait_idle("stall", 300);

        // Continuous scan: two passes, then drop continuous mid second pass
        rand_vals();
        continuous = 1'b1;
        push_pass(4'b1001);
        push_pass(4'b1001);
        base = n_acc;
        do_start(4'b1001);
        n = 0;
        while (n_acc < base + 3 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cont_progress", n_acc - base, 3);
        continuous = 1'b0;
        wait_idle("continuous", 200);
        chk("cont_count", n_acc - base, 4);

        // Empty mask start is ignored
        do_start(4'b0000);
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || sar_resetn !== 1'b0) bad++;
        end
        chk("zero_mask_idle", bad, 0);

        // Reset during CONV cycle 3 aborts with no result
        rand_vals();
        push_pass(4'b0100);
        do_start(4'b0100);
        n = 0;
        while (!sar_resetn && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("conv_entered", int'(sar_resetn), 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_mux_sel", int'(mux_sel), 0);
        chk("abort_sar_resetn", int'(sar_resetn), 0);
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_res_data", int'(res_data), 0);
        chk("abort_res_ch", int'(res_ch), 0);
        q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("abort_quiet", bad, 0);

        // Randomised passes with random backpressure and ignored restarts while busy
        rnd_ready = 1'b1;
        for (int it = 0; it < 8; it++) begin
            rand_vals();
            m = 4'($urandom_range(1, 15));
            push_pass(m);
            do_start(m);
            repeat (7) @(posedge clk);
            #1;
            ch_mask = 4'($urandom_range(0, 15));
            start   = 1'b1;
            @(posedge clk); #1;
            start   = 1'b0;
            wait_idle("random", 2000);
        end
        rnd_ready = 1'b0;
        @(posedge clk); #3;
        res_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
